// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiplier job sequencer.
package mul_pkg;

  localparam int W_DEF = 16;

  // One-hot-free binary encoding of the sequencer's job phases.
  typedef enum logic [2:0] {
    INIT,
    IDLE,
    START,
    LOAD_A,
    LOAD_B,
    WAIT,
    RESTART,
    OUT
  } state_e;

  // Product width for a W-bit operand pair.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mul_job_sequencer_if.sv
// Operand stream, core control/data bus and result stream of the sequencer.
interface mul_job_sequencer_if #(
  parameter int W = mul_pkg::W_DEF
);
  localparam int PW = mul_pkg::prod_w(W);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          mul_start;
  logic [W-1:0]  mul_data;
  logic          mul_restart;
  logic          mul_done;
  logic [PW-1:0] mul_product;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic          out_err;

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, mul_done, mul_product, out_ready,
    output in_ready, mul_start, mul_data, mul_restart, out_valid, out_data, out_err
  );

  // Environment side: operand producer, core and result consumer.
  modport master (
    output in_valid, in_a, in_b, mul_done, mul_product, out_ready,
    input  in_ready, mul_start, mul_data, mul_restart, out_valid, out_data, out_err
  );

endinterface

// File: rtl/mul_timeout_counter.sv
// Saturating WAIT-phase cycle counter; flags the last permitted cycle.
module mul_timeout_counter #(
  parameter int TIMEOUT = 70000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  // Count enabled cycles, holding at the expiry value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mul_job_sequencer.sv
// Front-end for the repeated-addition multiplier core: one job in flight,
// zero-operand bypass and a bounded wait for the core's done.
module mul_job_sequencer
  import mul_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = 70000
) (
  input  logic clk,
  input  logic rst_n,
  mul_job_sequencer_if.slave bus
);
  localparam int PW = prod_w(W);

  state_e        state;
  state_e        state_nxt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [PW-1:0] res_q;
  logic          err_q;

  logic          in_ready_d;
  logic          start_d;
  logic          restart_d;
  logic          out_valid_d;
  logic [W-1:0]  data_d;
  logic          tmr_clear;
  logic          tmr_en;
  logic          tmr_expired;

  mul_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // State register; reset lands in INIT so the core is always restarted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt   = state;
    in_ready_d  = 1'b0;
    start_d     = 1'b0;
    restart_d   = 1'b0;
    out_valid_d = 1'b0;
    data_d      = '0;
    tmr_clear   = 1'b0;
    tmr_en      = 1'b0;
    unique case (state)
      INIT: begin
        restart_d = 1'b1;
        state_nxt = IDLE;
      end
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid) begin
          state_nxt = ((bus.in_a == '0) || (bus.in_b == '0)) ? OUT : START;
        end
      end
      START: begin
        start_d   = 1'b1;
        data_d    = a_q;
        state_nxt = LOAD_A;
      end
      LOAD_A: begin
        data_d    = a_q;
        state_nxt = LOAD_B;
      end
      LOAD_B: begin
        data_d    = b_q;
        tmr_clear = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        data_d = b_q;
        tmr_en = 1'b1;
        if (bus.mul_done || tmr_expired) begin
          state_nxt = RESTART;
        end
      end
      RESTART: begin
        restart_d = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        out_valid_d = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // Operand capture on accept; result capture on done (wins) or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            res_q <= '0;
            err_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.mul_done) begin
            res_q <= bus.mul_product;
            err_q <= 1'b0;
          end else if (tmr_expired) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_d;
  assign bus.mul_start   = start_d;
  assign bus.mul_data    = data_d;
  assign bus.mul_restart = restart_d;
  assign bus.out_valid   = out_valid_d;
  assign bus.out_data    = res_q;
  assign bus.out_err     = err_q;

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Bench for mul_job_sequencer: two instances (default and short timeout)
// share stimulus through a selector; a cycle-level core model answers the
// sequencer and a job-level reference model predicts every result.
module tb_mul_job_sequencer;
  localparam int W       = 16;
  localparam int T_MAIN  = 70000;
  localparam int T_SHORT = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic in_valid, mul_done, out_ready;
  logic [W-1:0] in_a, in_b;
  logic [2*W-1:0] mul_product;

  int total = 0;
  int bad   = 0;

  mul_job_sequencer_if #(.W(W)) bif ();
  mul_job_sequencer_if #(.W(W)) bif_t ();

  mul_job_sequencer #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  mul_job_sequencer #(.W(W), .TIMEOUT(T_SHORT)) dut_t (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif_t.slave)
  );

  always #5 clk = ~clk;

  assign bif.in_valid      = in_valid & ~sel;
  assign bif_t.in_valid    = in_valid & sel;
  assign bif.in_a          = in_a;
  assign bif_t.in_a        = in_a;
  assign bif.in_b          = in_b;
  assign bif_t.in_b        = in_b;
  assign bif.mul_done      = mul_done;
  assign bif_t.mul_done    = mul_done;
  assign bif.mul_product   = mul_product;
  assign bif_t.mul_product = mul_product;
  assign bif.out_ready     = out_ready & ~sel;
  assign bif_t.out_ready   = out_ready & sel;

  logic o_in_ready, o_mul_start, o_mul_restart, o_out_valid, o_out_err;
  logic [W-1:0]   o_mul_data;
  logic [2*W-1:0] o_out_data;
  assign o_in_ready    = sel ? bif_t.in_ready    : bif.in_ready;
  assign o_mul_start   = sel ? bif_t.mul_start   : bif.mul_start;
  assign o_mul_restart = sel ? bif_t.mul_restart : bif.mul_restart;
  assign o_out_valid   = sel ? bif_t.out_valid   : bif.out_valid;
  assign o_out_err     = sel ? bif_t.out_err     : bif.out_err;
  assign o_mul_data    = sel ? bif_t.mul_data    : bif.mul_data;
  assign o_out_data    = sel ? bif_t.out_data    : bif.out_data;

  // Observations of the last job.
  int r_wait, r_start_n, r_start_cnt, r_restart_cnt, r_out_n;
  logic [W-1:0]   r_d1, r_d2, r_d3;
  logic [2*W-1:0] r_data;
  logic r_err, r_hung, r_unstable, r_ready_busy, r_valid_after, r_ready_after;

  // Job-level reference model. d = WAIT cycle on which the core raises done
  // (0 = never); the job times out on WAIT cycle t.
  function automatic bit m_zero(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a == 0) || (b == 0);
  endfunction

  function automatic bit m_done_ok(input int d, input int t);
    return (d > 0) && (d <= t);
  endfunction

  function automatic logic [2*W-1:0] m_data(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input int d, input int t);
    logic [2*W-1:0] aw, bw;
    aw = {{W{1'b0}}, a};
    bw = {{W{1'b0}}, b};
    if (m_zero(a, b) || !m_done_ok(d, t)) return '0;
    return aw * bw;
  endfunction

  function automatic logic m_err(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int d, input int t);
    return !m_zero(a, b) && !m_done_ok(d, t);
  endfunction

  // Cycle (counted from the accept edge) on which out_valid first shows.
  function automatic int m_out_n(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int d, input int t);
    if (m_zero(a, b)) return 1;
    return 3 + (m_done_ok(d, t) ? d : t) + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one job and plays the core: done is raised d cycles after the
  // load-B cycle and held until the core sees its restart.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int d,
                         input int stall, input bit hold,
                         input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [2*W-1:0] p, aw, bw;
    int n;
    bit done_now;
    aw = {{W{1'b0}}, a};
    bw = {{W{1'b0}}, b};
    p  = aw * bw;
    r_wait = 0; r_start_n = 0; r_start_cnt = 0; r_restart_cnt = 0; r_out_n = 0;
    r_d1 = '0; r_d2 = '0; r_d3 = '0; r_data = '0; r_err = 1'b0; r_hung = 1'b0;
    r_unstable = 1'b0; r_ready_busy = 1'b0; r_valid_after = 1'b0; r_ready_after = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0; mul_done = 1'b0;
    mul_product = $urandom;
    while (!o_in_ready && r_wait < 200) begin
      tick();
      r_wait++;
    end
    if (!o_in_ready) begin
      r_hung = 1'b1;
      in_valid = 1'b0;
      return;
    end
    tick();
    if (hold) begin
      in_a = na;
      in_b = nb;
    end else begin
      in_valid = 1'b0;
    end
    n = 1;
    while (r_out_n == 0 && n <= 150) begin
      if (o_mul_start) begin
        r_start_cnt++;
        if (r_start_n == 0) r_start_n = n;
      end
      if (n == 1) r_d1 = o_mul_data;
      if (n == 2) r_d2 = o_mul_data;
      if (n == 3) r_d3 = o_mul_data;
      if (o_in_ready) r_ready_busy = 1'b1;
      if (o_out_valid) begin
        r_out_n = n;
        r_data  = o_out_data;
        r_err   = o_out_err;
      end else begin
        done_now = (d > 0) && (n >= 3 + d) && (r_restart_cnt == 0);
        mul_done = done_now;
        mul_product = done_now ? p : $urandom;
        if (o_mul_restart) r_restart_cnt++;
        tick();
        n++;
      end
    end
    mul_done = 1'b0;
    if (r_out_n == 0) begin
      r_hung = 1'b1;
      return;
    end
    for (int k = 0; k < stall; k++) begin
      tick();
      if (!o_out_valid || o_out_data !== r_data || o_out_err !== r_err) r_unstable = 1'b1;
      if (o_in_ready) r_ready_busy = 1'b1;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    r_valid_after = o_out_valid;
    r_ready_after = o_in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    mul_done = 1'b0; mul_product = '0; out_ready = 1'b0;
    tick(); tick();
    total++;
    if ({o_mul_restart, o_mul_start, o_in_ready, o_out_valid, o_out_err} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=10000",
               {o_mul_restart, o_mul_start, o_in_ready, o_out_valid, o_out_err});
    end
    total++;
    if (o_mul_data !== '0 || o_out_data !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h want=0/0", o_mul_data, o_out_data);
    end
    #2 rst_n = 1'b1;
    tick();
    total++;
    if ({o_mul_restart, o_in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL reset_to_idle got=%b want=01", {o_mul_restart, o_in_ready});
    end
  endtask

  task automatic test_normal();
    sel = 1'b0;
    run_job(16'd7, 16'd5, 9, 0, 1'b0, '0, '0);
    total++;
    if (r_hung !== 1'b0) begin bad++; $display("FAIL normal_hung got=%b want=0", r_hung); end
    total++;
    if (r_start_n != 1 || r_start_cnt != 1) begin
      bad++; $display("FAIL normal_start got=cycle%0d x%0d want=cycle1 x1", r_start_n, r_start_cnt);
    end
    total++;
    if ({r_d1, r_d2, r_d3} !== {16'd7, 16'd7, 16'd5}) begin
      bad++; $display("FAIL normal_bus got=%0d,%0d,%0d want=7,7,5", r_d1, r_d2, r_d3);
    end
    total++;
    if (r_restart_cnt != 1) begin
      bad++; $display("FAIL normal_restart got=%0d want=1", r_restart_cnt);
    end
    total++;
    if (r_out_n != 14) begin bad++; $display("FAIL normal_latency got=%0d want=14", r_out_n); end
    total++;
    if (r_data !== 32'd35 || r_err !== 1'b0) begin
      bad++; $display("FAIL normal_result got=%0d err=%b want=35 err=0", r_data, r_err);
    end
    total++;
    if (r_valid_after !== 1'b0 || r_ready_busy !== 1'b0 || r_ready_after !== 1'b1) begin
      bad++; $display("FAIL normal_handshake got=%b%b%b want=001",
                      r_valid_after, r_ready_busy, r_ready_after);
    end
  endtask

  task automatic test_bypass();
    sel = 1'b0;
    run_job(16'h1234, 16'h0000, 5, 0, 1'b0, '0, '0);
    total++;
    if (r_start_cnt != 0 || r_restart_cnt != 0) begin
      bad++; $display("FAIL bypass_core got=start%0d restart%0d want=0 0", r_start_cnt, r_restart_cnt);
    end
    total++;
    if (r_out_n != 1) begin bad++; $display("FAIL bypass_latency got=%0d want=1", r_out_n); end
    total++;
    if (r_data !== '0 || r_err !== 1'b0) begin
      bad++; $display("FAIL bypass_result got=%h err=%b want=0 err=0", r_data, r_err);
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    run_job(16'hFFFF, 16'hFFFF, 4, 10, 1'b0, '0, '0);
    total++;
    if (r_data !== 32'hFFFE0001 || r_err !== 1'b0) begin
      bad++; $display("FAIL bp_result got=%h err=%b want=fffe0001 err=0", r_data, r_err);
    end
    total++;
    if (r_unstable !== 1'b0) begin bad++; $display("FAIL bp_stable got=%b want=0", r_unstable); end
    total++;
    if (r_ready_busy !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", r_ready_busy); end
    total++;
    if (r_valid_after !== 1'b0 || r_ready_after !== 1'b1) begin
      bad++; $display("FAIL bp_release got=%b%b want=01", r_valid_after, r_ready_after);
    end
  endtask

  task automatic test_timeout();
    sel = 1'b1;
    run_job(16'd9, 16'd9, 0, 0, 1'b0, '0, '0);
    total++;
    if (r_err !== 1'b1 || r_data !== '0) begin
      bad++; $display("FAIL timeout_result got=%h err=%b want=0 err=1", r_data, r_err);
    end
    total++;
    if (r_restart_cnt != 1 || r_out_n != 13) begin
      bad++; $display("FAIL timeout_timing got=restart%0d out%0d want=1 13", r_restart_cnt, r_out_n);
    end
    run_job(16'd9, 16'd9, T_SHORT, 0, 1'b0, '0, '0);
    total++;
    if (r_err !== 1'b0 || r_data !== 32'd81 || r_out_n != 13) begin
      bad++; $display("FAIL timeout_tie got=%0d err=%b out%0d want=81 err=0 out13", r_data, r_err, r_out_n);
    end
    run_job(16'd9, 16'd9, T_SHORT + 1, 0, 1'b0, '0, '0);
    total++;
    if (r_err !== 1'b1 || r_data !== '0 || r_out_n != 13) begin
      bad++; $display("FAIL timeout_late got=%h err=%b out%0d want=0 err=1 out13", r_data, r_err, r_out_n);
    end
  endtask

  task automatic test_reset_mid();
    int g, outs, rsts;
    sel = 1'b0; out_ready = 1'b0; mul_done = 1'b0;
    in_a = 16'd3; in_b = 16'd3; in_valid = 1'b1;
    g = 0;
    while (!o_in_ready && g < 50) begin tick(); g++; end
    total++;
    if (!o_in_ready) begin bad++; $display("FAIL rstmid_accept got=in_ready0 want=in_ready1"); end
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({o_mul_restart, o_mul_start, o_in_ready, o_out_valid, o_out_err} !== 5'b10000) begin
      bad++;
      $display("FAIL rstmid_ctrl got=%b want=10000",
               {o_mul_restart, o_mul_start, o_in_ready, o_out_valid, o_out_err});
    end
    total++;
    if (o_mul_data !== '0 || o_out_data !== '0) begin
      bad++; $display("FAIL rstmid_data got=%h/%h want=0/0", o_mul_data, o_out_data);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    total++;
    if ({o_mul_restart, o_in_ready} !== 2'b10) begin
      bad++; $display("FAIL rstmid_init got=%b want=10", {o_mul_restart, o_in_ready});
    end
    tick();
    total++;
    if ({o_mul_restart, o_in_ready} !== 2'b01) begin
      bad++; $display("FAIL rstmid_idle got=%b want=01", {o_mul_restart, o_in_ready});
    end
    outs = 0; rsts = 0;
    repeat (10) begin
      tick();
      if (o_out_valid) outs++;
      if (o_mul_restart) rsts++;
    end
    total++;
    if (outs != 0 || rsts != 0) begin
      bad++; $display("FAIL rstmid_quiet got=valid%0d restart%0d want=0 0", outs, rsts);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_job(16'd3, 16'd4, 3, 2, 1'b1, 16'd2, 16'd2);
    total++;
    if (r_data !== 32'd12 || r_ready_busy !== 1'b0) begin
      bad++; $display("FAIL b2b_first got=%0d busy=%b want=12 busy=0", r_data, r_ready_busy);
    end
    run_job(16'd2, 16'd2, 2, 0, 1'b0, '0, '0);
    total++;
    if (r_wait != 0 || r_data !== 32'd4 || r_err !== 1'b0) begin
      bad++; $display("FAIL b2b_second got=wait%0d %0d err=%b want=wait0 4 err=0", r_wait, r_data, r_err);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int d, st, t;
    for (int i = 0; i < 20; i++) begin
      sel = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      b   = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      t   = sel ? T_SHORT : T_MAIN;
      d   = sel ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 12));
      st  = int'($urandom_range(0, 3));
      run_job(a, b, d, st, 1'b0, '0, '0);
      total++;
      if (r_data !== m_data(a, b, d, t) || r_err !== m_err(a, b, d, t)) begin
        bad++; $display("FAIL rand%0d_result a=%h b=%h d=%0d got=%h err=%b want=%h err=%b",
                        i, a, b, d, r_data, r_err, m_data(a, b, d, t), m_err(a, b, d, t));
      end
      total++;
      if (r_out_n != m_out_n(a, b, d, t)) begin
        bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", i, r_out_n, m_out_n(a, b, d, t));
      end
      total++;
      if (r_restart_cnt != (m_zero(a, b) ? 0 : 1) || r_start_cnt != (m_zero(a, b) ? 0 : 1)) begin
        bad++; $display("FAIL rand%0d_core got=start%0d restart%0d want=%0d", i,
                        r_start_cnt, r_restart_cnt, m_zero(a, b) ? 0 : 1);
      end
      total++;
      if (r_valid_after !== 1'b0 || r_unstable !== 1'b0) begin
        bad++; $display("FAIL rand%0d_handshake got=%b%b want=00", i, r_valid_after, r_unstable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bypass();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=still running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
